// File: rtl/anim_step_sequencer.sv
// Animation step index generator: programmable prescaler driving a wrap-around
// 3-bit up/down counter with hold/single-step and one-shot modes.
// Optional ANIM_STEP_SYNC_EN adds a 2-flop synchronizer on i_step (latency 3 instead of 1).
module anim_step_sequencer #(
  parameter int BASE_DIV = 1000000,
  parameter int PRESC_W  = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_run,
  input  logic       i_dir,
  input  logic [2:0] i_speed,
  input  logic       i_oneshot,
  input  logic       i_step,
  input  logic       i_clear,
  output logic [2:0] o_count,
  output logic       o_tick,
  output logic       o_wrap,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [2:0]         count_q, count_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;
  logic               busy_q, busy_d;
  logic               step_prev_q, step_prev_d;

  logic               step_cur;
  logic               step_rise;
  logic [PRESC_W-1:0] terminal;
  logic               run_adv;
  logic               hold_adv;
  logic               advance;
  logic               wraps;
  logic [2:0]         next_count;

`ifdef ANIM_STEP_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d   = {sync_q[0], i_step};
    step_cur = sync_q[1];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end
`else
  always_comb begin
    step_cur = i_step;
  end
`endif

  // Terminal count follows i_speed combinationally so a speed change takes
  // effect on the very next prescaler update.
  always_comb begin
    terminal = PRESC_W'((BASE_DIV >> i_speed) - 1);
  end

  always_comb begin
    step_prev_d = step_cur;
    step_rise   = step_cur & ~step_prev_q;

    run_adv  = (state_q == S_RUN) && (presc_q == terminal);
    hold_adv = (state_q == S_HOLD) && step_rise;
    advance  = (run_adv || hold_adv) && !i_clear;

    next_count = i_dir ? (count_q - 3'd1) : (count_q + 3'd1);
    wraps      = i_dir ? (count_q == 3'd0) : (count_q == 3'd7);

    // Prescaler overshoot after a speed change clears without advancing.
    presc_d = presc_q;
    if (state_q != S_RUN || i_clear) begin
      presc_d = '0;
    end else if (presc_q >= terminal) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    count_d = count_q;
    if (i_clear) begin
      count_d = 3'd0;
    end else if (advance) begin
      count_d = next_count;
    end

    tick_d = advance;
    wrap_d = advance && wraps;
    busy_d = (state_q == S_RUN);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD: begin
        if (i_run) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!i_run) begin
          state_d = S_HOLD;
        end else if (i_oneshot && advance && wraps) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!i_run) begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_HOLD;
      presc_q     <= '0;
      count_q     <= 3'd0;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      busy_q      <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      count_q     <= count_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
      busy_q      <= busy_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign o_count = count_q;
  assign o_tick  = tick_q;
  assign o_wrap  = wrap_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_anim_step_sequencer.sv
// Directed, table-driven bench for anim_step_sequencer (BASE_DIV=16).
// Honours ANIM_STEP_SYNC_EN for the expected step latency.
module tb_anim_step_sequencer;

  localparam int BASE_DIV = 16;
  localparam int PRESC_W  = 8;
`ifdef ANIM_STEP_SYNC_EN
  localparam int STEP_LAT = 3;
`else
  localparam int STEP_LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, dir, oneshot, step, clear;
  logic [2:0] speed;
  logic [2:0] o_count;
  logic       o_tick, o_wrap, o_busy;

  typedef struct {
    logic       run;
    logic       dir;
    logic [2:0] speed;
    logic       oneshot;
    logic       step;
    logic       clear;
    int         cyc;
    logic [2:0] e_count;
    logic       e_tick;
    logic       e_wrap;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   ticks, wraps;

  always #5 clk = ~clk;

  anim_step_sequencer #(
    .BASE_DIV(BASE_DIV),
    .PRESC_W (PRESC_W)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_run    (run),
    .i_dir    (dir),
    .i_speed  (speed),
    .i_oneshot(oneshot),
    .i_step   (step),
    .i_clear  (clear),
    .o_count  (o_count),
    .o_tick   (o_tick),
    .o_wrap   (o_wrap),
    .o_busy   (o_busy)
  );

  task automatic add(input int r, input int d, input int sp, input int os, input int st,
                     input int cl, input int cyc, input int ec, input int et, input int ew,
                     input int eb);
    vec_t v;
    v.run     = 1'(r);
    v.dir     = 1'(d);
    v.speed   = 3'(sp);
    v.oneshot = 1'(os);
    v.step    = 1'(st);
    v.clear   = 1'(cl);
    v.cyc     = cyc;
    v.e_count = 3'(ec);
    v.e_tick  = 1'(et);
    v.e_wrap  = 1'(ew);
    v.e_busy  = 1'(eb);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    // run dir spd os step clr cyc | count tick wrap busy
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 14,  0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1,   1, 1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1,   1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 110, 7, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1,   0, 1, 1, 1);
    add(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 9,   0, 0, 0, 1);
    // prescaler is 10 here: switching to speed 2 must clear it without advancing
    add(1, 0, 2, 0, 0, 0, 1,   0, 0, 0, 1);
    add(1, 0, 2, 0, 0, 0, 3,   0, 0, 0, 1);
    add(1, 0, 2, 0, 0, 0, 1,   1, 1, 0, 1);
    add(1, 0, 2, 0, 0, 0, 4,   2, 1, 0, 1);
    add(1, 0, 2, 0, 0, 1, 1,   0, 0, 0, 1);
    add(1, 1, 2, 0, 0, 0, 3,   0, 0, 0, 1);
    add(1, 1, 2, 0, 0, 0, 1,   7, 1, 1, 1);
    add(1, 1, 2, 0, 0, 0, 4,   6, 1, 0, 1);
    add(1, 1, 2, 0, 0, 0, 4,   5, 1, 0, 1);
    add(0, 0, 2, 0, 0, 0, 1,   5, 0, 0, 1);
    add(0, 0, 2, 0, 0, 0, 1,   5, 0, 0, 0);
    add(0, 0, 2, 0, 0, 1, 1,   0, 0, 0, 0);
    // manual steps in HOLD
    add(0, 0, 2, 0, 1, 0, STEP_LAT - 1, 0, 0, 0, 0);
    add(0, 0, 2, 0, 1, 0, 1,            1, 1, 0, 0);
    add(0, 0, 2, 0, 1, 0, 4,            1, 0, 0, 0);
    add(0, 0, 2, 0, 0, 0, STEP_LAT + 1, 1, 0, 0, 0);
    add(0, 0, 2, 0, 1, 0, STEP_LAT - 1, 1, 0, 0, 0);
    add(0, 0, 2, 0, 1, 0, 1,            2, 1, 0, 0);
    add(0, 0, 2, 0, 1, 0, 2,            2, 0, 0, 0);
    add(0, 0, 2, 0, 0, 0, STEP_LAT + 1, 2, 0, 0, 0);
    // step pulses while running are ignored
    add(1, 0, 2, 0, 0, 0, 1,   2, 0, 0, 0);
    add(1, 0, 2, 0, 1, 0, 2,   2, 0, 0, 1);
    add(1, 0, 2, 0, 0, 0, 1,   2, 0, 0, 1);
    add(1, 0, 2, 0, 0, 0, 1,   3, 1, 0, 1);
    // one-shot
    add(1, 0, 2, 1, 0, 1, 1,   0, 0, 0, 1);
    add(1, 0, 2, 1, 0, 0, 31,  7, 0, 0, 1);
    add(1, 0, 2, 1, 0, 0, 1,   0, 1, 1, 1);
    add(1, 0, 2, 1, 0, 0, 1,   0, 0, 0, 0);
    add(1, 0, 2, 1, 0, 0, 100, 0, 0, 0, 0);
    add(0, 0, 2, 0, 0, 0, 1,   0, 0, 0, 0);
    add(1, 0, 2, 0, 0, 0, 1,   0, 0, 0, 0);
    add(1, 0, 2, 0, 0, 0, 3,   0, 0, 0, 1);
    add(1, 0, 2, 0, 0, 0, 1,   1, 1, 0, 1);
    add(1, 0, 2, 0, 0, 0, 20,  6, 1, 0, 1);
    add(1, 0, 2, 0, 0, 0, 3,   6, 0, 0, 1);
    // clear lands on the same edge as an advance at count 6
    add(1, 0, 2, 0, 0, 1, 1,   0, 0, 0, 1);
    add(1, 0, 2, 0, 0, 0, 4,   1, 1, 0, 1);
    add(1, 0, 2, 0, 0, 0, 16,  5, 1, 0, 1);

    rst_n   = 1'b0;
    run     = 1'b0;
    dir     = 1'b0;
    speed   = 3'd0;
    oneshot = 1'b0;
    step    = 1'b0;
    clear   = 1'b0;
    #12;
    check("reset_count", -1, 8'(o_count), 8'd0);
    check("reset_tick",  -1, 8'(o_tick),  8'd0);
    check("reset_wrap",  -1, 8'(o_wrap),  8'd0);
    check("reset_busy",  -1, 8'(o_busy),  8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run     = vecs[i].run;
      dir     = vecs[i].dir;
      speed   = vecs[i].speed;
      oneshot = vecs[i].oneshot;
      step    = vecs[i].step;
      clear   = vecs[i].clear;
      repeat (vecs[i].cyc) @(posedge clk);
      #1;
      check("count", i, 8'(o_count), 8'(vecs[i].e_count));
      check("tick",  i, 8'(o_tick),  8'(vecs[i].e_tick));
      check("wrap",  i, 8'(o_wrap),  8'(vecs[i].e_wrap));
      check("busy",  i, 8'(o_busy),  8'(vecs[i].e_busy));
    end

    // Asynchronous reset mid-run at count 5, sampled with no clock edge in between.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", -2, 8'(o_count), 8'd0);
    check("async_rst_busy",  -2, 8'(o_busy),  8'd0);
    check("async_rst_tick",  -2, 8'(o_tick),  8'd0);
    @(posedge clk);
    #1;
    check("rst_held_count", -2, 8'(o_count), 8'd0);

    // Full 8-step cycle at speed 0: 8 ticks, exactly one wrap.
    run     = 1'b1;
    dir     = 1'b0;
    speed   = 3'd0;
    oneshot = 1'b0;
    step    = 1'b0;
    clear   = 1'b0;
    rst_n   = 1'b1;
    ticks   = 0;
    wraps   = 0;
    for (int c = 0; c < 130; c++) begin
      @(posedge clk);
      #1;
      if (o_tick) ticks++;
      if (o_wrap) wraps++;
    end
    check("cycle_ticks", -3, 8'(ticks),   8'd8);
    check("cycle_wraps", -3, 8'(wraps),   8'd1);
    check("cycle_count", -3, 8'(o_count), 8'd0);
    check("cycle_busy",  -3, 8'(o_busy),  8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
